// File: rtl/mem_ctrl.sv
// Memory controller: serialises ICache fetches and LSB loads/stores onto a byte-wide,
// registered-read RAM/IO port. One request in service at a time, LSB has priority.
module mem_ctrl #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = 32'h0003_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              ic_enable,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic              ic_clear,
    output logic              ic_valid,
    output logic [31:0]       ic_data,
    input  logic              lsb_enable,
    input  logic              lsb_wr,
    input  logic [1:0]        lsb_len,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [31:0]       lsb_wdata,
    output logic              lsb_valid,
    output logic [31:0]       lsb_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] base_reg, base_next;
    logic [2:0]        len_reg, len_next;
    logic [2:0]        cnt_reg, cnt_next;
    logic              owner_lsb_reg, owner_lsb_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [31:0]       buf_reg, buf_next;
    logic              ic_valid_reg, ic_valid_next;
    logic              lsb_valid_reg, lsb_valid_next;
    logic              mem_wr_reg, mem_wr_next;
    logic [ADDR_W-1:0] mem_a_reg, mem_a_next;
    logic [7:0]        mem_dout_reg, mem_dout_next;
    logic [31:0]       ic_data_reg, ic_data_next;
    logic [31:0]       lsb_rdata_reg, lsb_rdata_next;

    logic [7:0]        wbyte [4];
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] nxt_addr;
    logic [1:0]        rx_idx;
    logic [2:0]        req_len;

    for (genvar gi = 0; gi < 4; gi++) begin : g_wbyte
        assign wbyte[gi] = wdata_reg[8*gi +: 8];
    end

    function automatic logic is_io(input logic [ADDR_W-1:0] a);
        return a >= IO_BASE;
    endfunction

    assign cur_addr = base_reg + ADDR_W'(cnt_reg);
    assign nxt_addr = base_reg + ADDR_W'(cnt_reg + 3'd1);
    // Byte arriving now was addressed two edges ago, i.e. one behind the edge count.
    assign rx_idx   = 2'(cnt_reg - 3'd1);
    assign req_len  = (lsb_len == 2'd0) ? 3'd1 : (lsb_len == 2'd1) ? 3'd2 : 3'd4;

    always_comb begin
        state_next     = state_reg;
        base_next      = base_reg;
        len_next       = len_reg;
        cnt_next       = cnt_reg;
        owner_lsb_next = owner_lsb_reg;
        wdata_next     = wdata_reg;
        buf_next       = buf_reg;
        ic_valid_next  = 1'b0;
        lsb_valid_next = 1'b0;
        mem_wr_next    = 1'b0;
        mem_a_next     = mem_a_reg;
        mem_dout_next  = mem_dout_reg;
        ic_data_next   = ic_data_reg;
        lsb_rdata_next = lsb_rdata_reg;

        case (state_reg)
            IDLE: begin
                if (lsb_enable) begin
                    owner_lsb_next = 1'b1;
                    base_next      = lsb_addr;
                    len_next       = req_len;
                    wdata_next     = lsb_wdata;
                    buf_next       = '0;
                    cnt_next       = '0;
                    if (lsb_wr) begin
                        state_next = WRITE;
                        if (!(is_io(lsb_addr) && io_buffer_full)) begin
                            mem_wr_next   = 1'b1;
                            mem_a_next    = lsb_addr;
                            mem_dout_next = lsb_wdata[7:0];
                            cnt_next      = 3'd1;
                        end
                    end else begin
                        state_next = READ;
                        mem_a_next = lsb_addr;
                    end
                end else if (ic_enable) begin
                    owner_lsb_next = 1'b0;
                    base_next      = ic_addr;
                    len_next       = 3'd4;
                    buf_next       = '0;
                    cnt_next       = '0;
                    state_next     = READ;
                    mem_a_next     = ic_addr;
                end
            end
            READ: begin
                if (!owner_lsb_reg && ic_clear) begin
                    state_next = IDLE;
                end else begin
                    if (cnt_reg + 3'd1 < len_reg) begin
                        mem_a_next = nxt_addr;
                    end
                    if (cnt_reg != 3'd0) begin
                        buf_next[{rx_idx, 3'b000} +: 8] = mem_din;
                    end
                    if (cnt_reg == len_reg) begin
                        state_next = DONE;
                        if (owner_lsb_reg) begin
                            lsb_valid_next = 1'b1;
                            lsb_rdata_next = buf_next;
                        end else begin
                            ic_valid_next = 1'b1;
                            ic_data_next  = buf_next;
                        end
                    end
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            WRITE: begin
                if (cnt_reg == len_reg) begin
                    state_next     = DONE;
                    lsb_valid_next = 1'b1;
                    lsb_rdata_next = '0;
                end else if (!(is_io(cur_addr) && io_buffer_full)) begin
                    mem_wr_next   = 1'b1;
                    mem_a_next    = cur_addr;
                    mem_dout_next = wbyte[cnt_reg[1:0]];
                    cnt_next      = cnt_reg + 3'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            base_reg      <= '0;
            len_reg       <= '0;
            cnt_reg       <= '0;
            owner_lsb_reg <= 1'b0;
            wdata_reg     <= '0;
            buf_reg       <= '0;
            ic_valid_reg  <= 1'b0;
            lsb_valid_reg <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_a_reg     <= '0;
            mem_dout_reg  <= '0;
            ic_data_reg   <= '0;
            lsb_rdata_reg <= '0;
        end else if (rdy) begin
            state_reg     <= state_next;
            base_reg      <= base_next;
            len_reg       <= len_next;
            cnt_reg       <= cnt_next;
            owner_lsb_reg <= owner_lsb_next;
            wdata_reg     <= wdata_next;
            buf_reg       <= buf_next;
            ic_valid_reg  <= ic_valid_next;
            lsb_valid_reg <= lsb_valid_next;
            mem_wr_reg    <= mem_wr_next;
            mem_a_reg     <= mem_a_next;
            mem_dout_reg  <= mem_dout_next;
            ic_data_reg   <= ic_data_next;
            lsb_rdata_reg <= lsb_rdata_next;
        end
    end

    // A flush arriving in the completion cycle suppresses the fetch result immediately.
    assign ic_valid  = ic_valid_reg & ~ic_clear;
    assign ic_data   = ic_data_reg;
    assign lsb_valid = lsb_valid_reg;
    assign lsb_rdata = lsb_rdata_reg;
    assign mem_wr    = mem_wr_reg;
    assign mem_a     = mem_a_reg;
    assign mem_dout  = mem_dout_reg;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomised + directed bench for mem_ctrl: byte-map reference model, expected responses
// queued at issue time and popped by an independent monitor on each valid pulse.
module tb_mem_ctrl;

    localparam logic [31:0] IO_BASE = 32'h0003_0000;

    logic        clk = 1'b0;
    logic        rst, rdy, ic_enable, ic_clear, lsb_enable, lsb_wr, io_buffer_full;
    logic [31:0] ic_addr, lsb_addr, lsb_wdata, ic_data, lsb_rdata, mem_a;
    logic [1:0]  lsb_len;
    logic [7:0]  mem_din, mem_dout;
    logic        ic_valid, lsb_valid, mem_wr;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(32), .IO_BASE(IO_BASE)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ic_enable(ic_enable), .ic_addr(ic_addr), .ic_clear(ic_clear),
        .ic_valid(ic_valid), .ic_data(ic_data),
        .lsb_enable(lsb_enable), .lsb_wr(lsb_wr), .lsb_len(lsb_len),
        .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .lsb_valid(lsb_valid), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    logic [7:0]  ram [logic [31:0]];
    logic [7:0]  mdl [logic [31:0]];
    logic [39:0] wr_log [$];
    logic [31:0] trace [$];
    logic [31:0] ic_q [$];
    logic [31:0] lsb_q [$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        edge_rdy = 1'b1;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] mdl_rd(input logic [31:0] a);
        if (mdl.exists(a)) return mdl[a];
        return init_byte(a);
    endfunction

    task automatic preset(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        mdl[a] = b;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // External RAM/IO: registered read, frozen together with the controller when rdy=0.
    initial begin
        mem_din = 8'h00;
        forever begin
            @(posedge clk);
            if (rdy) begin
                mem_din <= ram_rd(mem_a);
                if (mem_wr) begin
                    ram[mem_a] = mem_dout;
                    wr_log.push_back({mem_a, mem_dout});
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        edge_rdy = rdy;
    end

    initial begin : monitor
        logic        prev_ic, prev_lsb;
        logic [31:0] exp;
        prev_ic = 1'b0;
        prev_lsb = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (ic_valid && !(prev_ic && !edge_rdy)) begin
                n_checks++;
                if (prev_ic) begin
                    n_fail++;
                    $display("FAIL ic_pulse: ic_valid high for 2 live cycles, expected 1");
                end else if (ic_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ic_spurious: ic_valid=1 data=%h, expected no valid", ic_data);
                end else begin
                    exp = ic_q.pop_front();
                    if (ic_data !== exp) begin
                        n_fail++;
                        $display("FAIL ic_data: got %h, expected %h", ic_data, exp);
                    end else
                        $display("[%0t] IC  fetch  data=%h", $time, ic_data);
                end
            end
            if (lsb_valid && !(prev_lsb && !edge_rdy)) begin
                n_checks++;
                if (prev_lsb) begin
                    n_fail++;
                    $display("FAIL lsb_pulse: lsb_valid high for 2 live cycles, expected 1");
                end else if (lsb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL lsb_spurious: lsb_valid=1 rdata=%h, expected no valid", lsb_rdata);
                end else begin
                    exp = lsb_q.pop_front();
                    if (lsb_rdata !== exp) begin
                        n_fail++;
                        $display("FAIL lsb_rdata: got %h, expected %h", lsb_rdata, exp);
                    end else
                        $display("[%0t] LSB done   rdata=%h", $time, lsb_rdata);
                end
            end
            prev_ic = ic_valid;
            prev_lsb = lsb_valid;
        end
    end

    // Issues one request, returns edges from request to valid (E0..E(valid) inclusive).
    task automatic run_req(input bit is_lsb, input bit wr, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int clear_at, input int freeze_at, input int full_cycles,
                           output int lat);
        int          n;
        logic [31:0] exp;
        n = !is_lsb ? 4 : (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        @(negedge clk);
        #2;
        trace.delete();
        exp = '0;
        if (is_lsb && wr) begin
            for (int k = 0; k < n; k++) mdl[addr + 32'(k)] = wdata[8*k +: 8];
            lsb_q.push_back(32'h0);
        end else begin
            for (int k = 0; k < n; k++) exp[8*k +: 8] = mdl_rd(addr + 32'(k));
            if (clear_at < 0) begin
                if (is_lsb) lsb_q.push_back(exp);
                else ic_q.push_back(exp);
            end
        end
        if (is_lsb) begin
            lsb_enable = 1'b1; lsb_wr = wr; lsb_len = len; lsb_addr = addr; lsb_wdata = wdata;
        end else begin
            ic_enable = 1'b1; ic_addr = addr;
        end
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            ic_clear = (i == clear_at);
            if (i == clear_at) ic_enable = 1'b0;
            rdy = !(freeze_at >= 0 && i >= freeze_at && i < freeze_at + 2);
            io_buffer_full = (i < full_cycles);
            @(negedge clk);
            #2;
            trace.push_back(mem_a);
            if (clear_at >= 0 && i >= clear_at + 4) begin
                lat = i + 1;
                break;
            end
            if (is_lsb ? lsb_valid : ic_valid) begin
                lat = i + 1;
                break;
            end
        end
        lsb_enable = 1'b0; ic_enable = 1'b0; ic_clear = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no valid within 200 cycles for addr %h", addr);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, li, ci;
        logic [31:0] a;
        rst = 1'b1; rdy = 1'b1; ic_enable = 0; ic_clear = 0; lsb_enable = 0; lsb_wr = 0;
        io_buffer_full = 0; ic_addr = 0; lsb_addr = 0; lsb_wdata = 0; lsb_len = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ic_valid", 32'(ic_valid), 0);
        check("rst_lsb_valid", 32'(lsb_valid), 0);
        check("rst_mem_wr", 32'(mem_wr), 0);
        check("rst_mem_a", mem_a, 0);
        check("rst_mem_dout", 32'(mem_dout), 0);
        check("rst_ic_data", ic_data, 0);
        check("rst_lsb_rdata", lsb_rdata, 0);
        rst = 1'b0;

        // Instruction fetch
        preset(32'h100, 8'h13); preset(32'h101, 8'h05); preset(32'h102, 8'h00); preset(32'h103, 8'h00);
        run_req(0, 0, 2'd2, 32'h100, 0, -1, -1, 0, lat);
        check("fetch_latency", 32'(lat), 6);
        for (int k = 0; k < 5; k++) check("fetch_addr", trace[k], 32'h100 + 32'(k < 4 ? k : 3));

        // Halfword load
        preset(32'h1FE, 8'hAA); preset(32'h1FF, 8'hBB);
        run_req(1, 0, 2'd1, 32'h1FE, 0, -1, -1, 0, lat);
        check("load2_latency", 32'(lat), 4);

        // Word store then readback
        wr_log.delete();
        run_req(1, 1, 2'd2, 32'h200, 32'hDEADBEEF, -1, -1, 0, lat);
        check("store4_latency", 32'(lat), 5);
        check("store4_nwrites", 32'(wr_log.size()), 4);
        for (int k = 0; k < 4 && k < wr_log.size(); k++)
            check("store4_byte", 32'(wr_log[k]), 32'({32'h200 + 32'(k), 8'(32'hDEADBEEF >> (8*k))}));
        run_req(1, 0, 2'd2, 32'h200, 0, -1, -1, 0, lat);

        // Simultaneous requests: LSB first, IC one edge after the LSB done cycle
        @(negedge clk);
        #2;
        lsb_q.push_back({16'h0, mdl_rd(32'h1FF), mdl_rd(32'h1FE)});
        ic_q.push_back({mdl_rd(32'h103), mdl_rd(32'h102), mdl_rd(32'h101), mdl_rd(32'h100)});
        lsb_enable = 1; lsb_wr = 0; lsb_len = 2'd1; lsb_addr = 32'h1FE; ic_enable = 1; ic_addr = 32'h100;
        li = -1; ci = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #2;
            if (lsb_valid && li < 0) begin li = i + 1; lsb_enable = 0; end
            if (ic_valid && ci < 0) begin ci = i + 1; ic_enable = 0; break; end
        end
        lsb_enable = 0; ic_enable = 0;
        check("arb_lsb_latency", 32'(li), 4);
        check("arb_ic_latency", 32'(ci), 11);

        // IO store under backpressure, and the non-IO neighbour ignores it
        wr_log.delete();
        run_req(1, 1, 2'd0, IO_BASE, 32'h000000A5, -1, -1, 3, lat);
        check("io_stall_latency", 32'(lat), 5);
        check("io_nwrites", 32'(wr_log.size()), 1);
        if (wr_log.size() > 0) check("io_write", 32'(wr_log[0]), 32'({IO_BASE, 8'hA5}));
        run_req(1, 1, 2'd0, IO_BASE - 1, 32'h0000003C, -1, -1, 3, lat);
        check("nonio_latency", 32'(lat), 2);

        // Flushed fetch, then a load with a 2-cycle freeze
        run_req(0, 0, 2'd2, 32'h100, 0, 2, -1, 0, lat);
        run_req(1, 0, 2'd2, 32'h200, 0, -1, 2, 0, lat);
        check("freeze_latency", 32'(lat), 8);

        // Wrapping load, illegal length treated as 4B
        run_req(1, 0, 2'd3, 32'hFFFF_FFFE, 0, -1, -1, 0, lat);
        check("wrap_latency", 32'(lat), 6);

        // Reset mid-store: two bytes already committed stay written
        @(negedge clk);
        #2;
        lsb_enable = 1; lsb_wr = 1; lsb_len = 2'd2; lsb_addr = 32'h300; lsb_wdata = 32'hCAFEF00D;
        repeat (2) begin @(negedge clk); #2; end
        rst = 1; lsb_enable = 0;
        @(negedge clk);
        #2;
        rst = 0;
        check("midrst_mem_wr", 32'(mem_wr), 0);
        check("midrst_mem_a", mem_a, 0);
        mdl[32'h300] = 8'h0D; mdl[32'h301] = 8'hF0;
        run_req(1, 0, 2'd2, 32'h300, 0, -1, -1, 0, lat);

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 2))
                0: a = 32'h100 + 32'($urandom_range(0, 63));
                1: a = IO_BASE - 4 + 32'($urandom_range(0, 7));
                default: a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            endcase
            run_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    a, $urandom, -1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6)) : -1,
                    int'($urandom_range(0, 3)), lat);
        end

        repeat (5) @(negedge clk);
        check("ic_q_drained", 32'(ic_q.size()), 0);
        check("lsb_q_drained", 32'(lsb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
